scheduler1_commit_retire: RTL and testbench
===========================================

// Module: scheduler1_commit_retire
// PURPOSE
//  In-order retire controller downstream of the 64 scheduler1 commit entries.
//  - Owns the commit ring's head (retire) and tail (allocate) pointers.
//  - Inspects the entries at head and head+1, strobes up to two commits per cycle and tells the entries when to clear.
//  - Forwards retired destination/flag information, one cycle later, to the rename/free-list stage.
// PARAMETERS
//  ENTRY_N   64  ring depth; pointers are 6 bits and wrap modulo 64. Fixed; no other value is supported.
//  CNT_W     32  width of the retired-instruction performance counter.
// PORTS
//  iCLOCK            in   1   clock
//  iRESET            in   1   asynchronous reset, active-high
//  iLOCK             in   1   allocation stall; mirrors the entries' lock
//  iRESTART_VALID    in   1   pipeline flush
//  iREGIST_0_VALID   in   1   allocate slot at tail
//  iREGIST_1_VALID   in   1   allocate slot at tail+1; requires iREGIST_0_VALID
//  oREGIST_POINTER   out  6   tail pointer, driven to the entries' iREGIST_POINTER
//  oFULL             out  1   fewer than 2 free slots (count > 62)
//  oEMPTY            out  1   count == 0
//  oHEAD_POINTER     out  6   head pointer; the external mux selects entries head and head+1
//  iHEADn_VALID      in   1   entry n valid (n=0: head, n=1: head+1)
//  iHEADn_EX_END     in   1   entry n has finished execution
//  iHEADn_WRITEBACK  in   1   entry n writes a register
//  iHEADn_MAKE_FLAGS in   1   entry n writes flags
//  iHEADn_FLAGS_PREG in   4   flags physical register
//  iHEADn_DEST_PREG  in   6   destination physical register
//  iHEADn_DEST_LREG  in   5   destination logical register
//  iHEADn_DEST_SYSREG in  1   destination is a system register
//  iHEADn_EX_BRANCH  in   1   entry n is a branch
//  iHEADn_PC         in   32  entry n program counter
//  oCOMMITn_VALID    out  1   combinational commit strobe for slot n
//  oCOMMITn_POINTER  out  6   entry index for slot n (head+n)
//  oRETIREn_VALID    out  1   registered retire notification for slot n
//  oRETIREn_*        out  -   registered copies of WRITEBACK, MAKE_FLAGS, FLAGS_PREG, DEST_PREG, DEST_LREG, DEST_SYSREG, EX_BRANCH, PC
//  oRETIRE_COUNT     out  CNT_W  total retired instructions; wraps
// BEHAVIOUR
//  Reset values
//  - head = tail = 0, count = 0, oRETIRE_COUNT = 0.
//  - All oRETIRE* = 0, oEMPTY = 1, oFULL = 0.
//  Commit decision (combinational, same cycle)
//  - c0 = !iRESTART_VALID & count>0 & iHEAD0_VALID & iHEAD0_EX_END.
//  - c1 = c0 & count>1 & iHEAD1_VALID & iHEAD1_EX_END & !iHEAD0_EX_BRANCH.
//    A branch always retires alone as the last instruction of its bundle.
//  - oCOMMITn_VALID = cn. Each entry sees its strobe and clears at the same edge the head advances, so no entry is committed twice.
//  - iLOCK does NOT gate retire.
//  Allocation
//  - alloc = iLOCK ? 0 : (iREGIST_1_VALID ? 2 : iREGIST_0_VALID ? 1).
//  - If oFULL=1, alloc is forced to 0; the request is dropped and the tail is unchanged.
//  Updates at posedge (6-bit pointers wrap: 63+1 = 0, 63+2 = 1)
//  - head += c0 + c1.
//  - tail += alloc.
//  - count += alloc - (c0 + c1); 7-bit, range 0..64.
//  - Simultaneous alloc and retire are both applied in the same cycle.
//  - oRETIRE_COUNT += c0 + c1.
//  Retire outputs
//  - oRETIREn_* register iHEADn_* when cn is set, giving 1-cycle latency.
//  - oRETIREn_VALID = cn delayed one cycle; payload fields are 0 when VALID=0.
//  Restart (iRESTART_VALID=1)
//  - Commit strobes are forced to 0 in that cycle.
//  - Next cycle: head = tail = count = 0 and oRETIRE*_VALID = 0. Matches the entries, which all clear on restart.
//  - Allocation in the restart cycle is discarded; oRETIRE_COUNT is kept.
//  Reset mid-operation
//  - Asynchronous; all state returns to reset values immediately.
//  Illegal inputs (simulation assertions only, no hardware response)
//  - iREGIST_1_VALID without iREGIST_0_VALID.
//  - iHEAD0_VALID=0 while count>0 for more than one cycle.
// TESTING
//  1. Reset, allocate 1 (tail 0->1), EX_END at entry 0 -> oCOMMIT0_VALID=1, POINTER=0; next cycle oRETIRE0_VALID=1, head=1, count=0.
//  2. Allocate 2 (entries 0,1), both EX_END in the same cycle -> c0=c1=1, head 0->2, oRETIRE_COUNT=2.
//  3. Head entry is a branch, head+1 done -> only c0 fires; c1 fires the following cycle.
//  4. Fill to count=63 -> oFULL=1; an iREGIST_0_VALID pulse is dropped, tail unchanged. Retire 2 at head=62 -> head wraps to 0.
//  5. Restart with count=10 and alloc=2 in the same cycle -> no commit strobes; next cycle head=tail=count=0, oEMPTY=1.
//  6. Alloc 2 while retiring 2 with count=5 -> count stays 5, head and tail each advance by 2.
//  7. Assert iRESET mid-stream while oRETIRE0_VALID=1 -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/scheduler1_commit_retire.sv
// scheduler1_commit_retire
//   In-order retire controller for the 64-entry scheduler1 commit ring.
//   It owns the head (retire) and tail (allocate) pointers. It inspects the
//   entries at head and head+1 and strobes up to two commits per cycle. One
//   cycle later it forwards the retired destination/flag payload to the
//   rename/free-list stage.
// Ports
//   iCLOCK, iRESET              clock, asynchronous active-high reset
//   iLOCK                       allocation stall (does not stall retire)
//   iRESTART_VALID              pipeline flush; ring empties next cycle
//   iREGIST_0/1_VALID           allocate one/two slots at tail
//   oREGIST_POINTER             tail pointer
//   oFULL / oEMPTY              fewer than two free slots / ring empty
//   oHEAD_POINTER               head pointer; selects the head/head+1 entries
//   iHEAD0_* / iHEAD1_*         state of the entries at head and head+1
//   oCOMMIT0/1_VALID, _POINTER  same-cycle commit strobes and entry indices
//   oRETIRE0/1_*                registered retire payload, zero when not valid
//   oRETIRE_COUNT               running count of retired instructions (wraps)
module scheduler1_commit_retire #(
   parameter int ENTRY_N = 64,
   parameter int CNT_W   = 32
) (
   input  logic             iCLOCK,
   input  logic             iRESET,
   input  logic             iLOCK,
   input  logic             iRESTART_VALID,
   input  logic             iREGIST_0_VALID,
   input  logic             iREGIST_1_VALID,
   output logic [5:0]       oREGIST_POINTER,
   output logic             oFULL,
   output logic             oEMPTY,
   output logic [5:0]       oHEAD_POINTER,
   input  logic             iHEAD0_VALID,
   input  logic             iHEAD0_EX_END,
   input  logic             iHEAD0_WRITEBACK,
   input  logic             iHEAD0_MAKE_FLAGS,
   input  logic [3:0]       iHEAD0_FLAGS_PREG,
   input  logic [5:0]       iHEAD0_DEST_PREG,
   input  logic [4:0]       iHEAD0_DEST_LREG,
   input  logic             iHEAD0_DEST_SYSREG,
   input  logic             iHEAD0_EX_BRANCH,
   input  logic [31:0]      iHEAD0_PC,
   input  logic             iHEAD1_VALID,
   input  logic             iHEAD1_EX_END,
   input  logic             iHEAD1_WRITEBACK,
   input  logic             iHEAD1_MAKE_FLAGS,
   input  logic [3:0]       iHEAD1_FLAGS_PREG,
   input  logic [5:0]       iHEAD1_DEST_PREG,
   input  logic [4:0]       iHEAD1_DEST_LREG,
   input  logic             iHEAD1_DEST_SYSREG,
   input  logic             iHEAD1_EX_BRANCH,
   input  logic [31:0]      iHEAD1_PC,
   output logic             oCOMMIT0_VALID,
   output logic [5:0]       oCOMMIT0_POINTER,
   output logic             oCOMMIT1_VALID,
   output logic [5:0]       oCOMMIT1_POINTER,
   output logic             oRETIRE0_VALID,
   output logic             oRETIRE0_WRITEBACK,
   output logic             oRETIRE0_MAKE_FLAGS,
   output logic [3:0]       oRETIRE0_FLAGS_PREG,
   output logic [5:0]       oRETIRE0_DEST_PREG,
   output logic [4:0]       oRETIRE0_DEST_LREG,
   output logic             oRETIRE0_DEST_SYSREG,
   output logic             oRETIRE0_EX_BRANCH,
   output logic [31:0]      oRETIRE0_PC,
   output logic             oRETIRE1_VALID,
   output logic             oRETIRE1_WRITEBACK,
   output logic             oRETIRE1_MAKE_FLAGS,
   output logic [3:0]       oRETIRE1_FLAGS_PREG,
   output logic [5:0]       oRETIRE1_DEST_PREG,
   output logic [4:0]       oRETIRE1_DEST_LREG,
   output logic             oRETIRE1_DEST_SYSREG,
   output logic             oRETIRE1_EX_BRANCH,
   output logic [31:0]      oRETIRE1_PC,
   output logic [CNT_W-1:0] oRETIRE_COUNT
);

   // Full as soon as a two-wide allocation could overflow the ring.
   localparam logic [6:0] L_FULL_LIMIT = 7'(ENTRY_N - 2);

   logic [5:0]       r_head;
   logic [5:0]       r_tail;
   logic [6:0]       r_count;
   logic [CNT_W-1:0] r_retire_count;
   logic             r_ret0_valid;
   logic             r_ret1_valid;
   // Payload packing: {writeback, make_flags, flags_preg, dest_preg, dest_lreg, dest_sysreg, ex_branch, pc}
   logic [50:0]      r_ret0_data;
   logic [50:0]      r_ret1_data;

   logic             w_commit0;
   logic             w_commit1;
   logic             w_full;
   logic [1:0]       w_alloc;
   logic [1:0]       w_retire_n;

   assign w_full    = r_count > L_FULL_LIMIT;
   assign w_commit0 = !iRESTART_VALID && (r_count != 7'd0) && iHEAD0_VALID && iHEAD0_EX_END;
   // A branch closes its retire bundle, so head+1 waits for the next cycle.
   assign w_commit1 = w_commit0 && (r_count > 7'd1) && iHEAD1_VALID && iHEAD1_EX_END
                      && !iHEAD0_EX_BRANCH;
   assign w_retire_n = {1'b0, w_commit0} + {1'b0, w_commit1};

   always_comb begin
      w_alloc = 2'd0;
      if (!iLOCK && !w_full) begin
         if (iREGIST_1_VALID)      w_alloc = 2'd2;
         else if (iREGIST_0_VALID) w_alloc = 2'd1;
      end
   end

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         r_head         <= 6'd0;
         r_tail         <= 6'd0;
         r_count        <= 7'd0;
         r_retire_count <= '0;
         r_ret0_valid   <= 1'b0;
         r_ret1_valid   <= 1'b0;
         r_ret0_data    <= '0;
         r_ret1_data    <= '0;
      end else begin
         // Commit strobes are already zero during restart, so the counter holds.
         r_retire_count <= r_retire_count + CNT_W'(w_retire_n);
         r_ret0_valid   <= w_commit0;
         r_ret1_valid   <= w_commit1;
         r_ret0_data    <= w_commit0 ? {iHEAD0_WRITEBACK, iHEAD0_MAKE_FLAGS, iHEAD0_FLAGS_PREG,
                                        iHEAD0_DEST_PREG, iHEAD0_DEST_LREG, iHEAD0_DEST_SYSREG,
                                        iHEAD0_EX_BRANCH, iHEAD0_PC} : '0;
         r_ret1_data    <= w_commit1 ? {iHEAD1_WRITEBACK, iHEAD1_MAKE_FLAGS, iHEAD1_FLAGS_PREG,
                                        iHEAD1_DEST_PREG, iHEAD1_DEST_LREG, iHEAD1_DEST_SYSREG,
                                        iHEAD1_EX_BRANCH, iHEAD1_PC} : '0;
         if (iRESTART_VALID) begin
            // Entries all clear on restart; any same-cycle allocation is lost with them.
            r_head  <= 6'd0;
            r_tail  <= 6'd0;
            r_count <= 7'd0;
         end else begin
            r_head  <= r_head + {4'd0, w_retire_n};
            r_tail  <= r_tail + {4'd0, w_alloc};
            r_count <= r_count + {5'd0, w_alloc} - {5'd0, w_retire_n};
         end
      end
   end

   assign oREGIST_POINTER  = r_tail;
   assign oHEAD_POINTER    = r_head;
   assign oFULL            = w_full;
   assign oEMPTY           = (r_count == 7'd0);
   assign oCOMMIT0_VALID   = w_commit0;
   assign oCOMMIT0_POINTER = r_head;
   assign oCOMMIT1_VALID   = w_commit1;
   assign oCOMMIT1_POINTER = r_head + 6'd1;
   assign oRETIRE_COUNT    = r_retire_count;

   assign oRETIRE0_VALID = r_ret0_valid;
   assign {oRETIRE0_WRITEBACK, oRETIRE0_MAKE_FLAGS, oRETIRE0_FLAGS_PREG, oRETIRE0_DEST_PREG,
           oRETIRE0_DEST_LREG, oRETIRE0_DEST_SYSREG, oRETIRE0_EX_BRANCH, oRETIRE0_PC} = r_ret0_data;
   assign oRETIRE1_VALID = r_ret1_valid;
   assign {oRETIRE1_WRITEBACK, oRETIRE1_MAKE_FLAGS, oRETIRE1_FLAGS_PREG, oRETIRE1_DEST_PREG,
           oRETIRE1_DEST_LREG, oRETIRE1_DEST_SYSREG, oRETIRE1_EX_BRANCH, oRETIRE1_PC} = r_ret1_data;

`ifndef SYNTHESIS
   // Illegal-input monitors; the hardware itself takes no action on these.
   logic r_head0_missing;
   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) r_head0_missing <= 1'b0;
      else        r_head0_missing <= (r_count != 7'd0) && !iHEAD0_VALID;
   end
   always @(posedge iCLOCK) begin
      if (!iRESET) begin
         assert (!(iREGIST_1_VALID && !iREGIST_0_VALID));
         assert (!(r_head0_missing && (r_count != 7'd0) && !iHEAD0_VALID));
      end
   end
`endif

endmodule

// File: tb/tb_scheduler1_commit_retire.sv
module tb_scheduler1_commit_retire;

   logic        iCLOCK = 1'b0;
   logic        iRESET, iLOCK, iRESTART_VALID, iREGIST_0_VALID, iREGIST_1_VALID;
   logic [5:0]  oREGIST_POINTER, oHEAD_POINTER;
   logic        oFULL, oEMPTY;
   logic        iHEAD0_VALID, iHEAD0_EX_END, iHEAD0_WRITEBACK, iHEAD0_MAKE_FLAGS;
   logic [3:0]  iHEAD0_FLAGS_PREG;
   logic [5:0]  iHEAD0_DEST_PREG;
   logic [4:0]  iHEAD0_DEST_LREG;
   logic        iHEAD0_DEST_SYSREG, iHEAD0_EX_BRANCH;
   logic [31:0] iHEAD0_PC;
   logic        iHEAD1_VALID, iHEAD1_EX_END, iHEAD1_WRITEBACK, iHEAD1_MAKE_FLAGS;
   logic [3:0]  iHEAD1_FLAGS_PREG;
   logic [5:0]  iHEAD1_DEST_PREG;
   logic [4:0]  iHEAD1_DEST_LREG;
   logic        iHEAD1_DEST_SYSREG, iHEAD1_EX_BRANCH;
   logic [31:0] iHEAD1_PC;
   logic        oCOMMIT0_VALID, oCOMMIT1_VALID;
   logic [5:0]  oCOMMIT0_POINTER, oCOMMIT1_POINTER;
   logic        oRETIRE0_VALID, oRETIRE0_WRITEBACK, oRETIRE0_MAKE_FLAGS;
   logic [3:0]  oRETIRE0_FLAGS_PREG;
   logic [5:0]  oRETIRE0_DEST_PREG;
   logic [4:0]  oRETIRE0_DEST_LREG;
   logic        oRETIRE0_DEST_SYSREG, oRETIRE0_EX_BRANCH;
   logic [31:0] oRETIRE0_PC;
   logic        oRETIRE1_VALID, oRETIRE1_WRITEBACK, oRETIRE1_MAKE_FLAGS;
   logic [3:0]  oRETIRE1_FLAGS_PREG;
   logic [5:0]  oRETIRE1_DEST_PREG;
   logic [4:0]  oRETIRE1_DEST_LREG;
   logic        oRETIRE1_DEST_SYSREG, oRETIRE1_EX_BRANCH;
   logic [31:0] oRETIRE1_PC;
   logic [31:0] oRETIRE_COUNT;

   scheduler1_commit_retire #(.ENTRY_N(64), .CNT_W(32)) dut (
      .iCLOCK(iCLOCK), .iRESET(iRESET), .iLOCK(iLOCK), .iRESTART_VALID(iRESTART_VALID),
      .iREGIST_0_VALID(iREGIST_0_VALID), .iREGIST_1_VALID(iREGIST_1_VALID),
      .oREGIST_POINTER(oREGIST_POINTER), .oFULL(oFULL), .oEMPTY(oEMPTY),
      .oHEAD_POINTER(oHEAD_POINTER),
      .iHEAD0_VALID(iHEAD0_VALID), .iHEAD0_EX_END(iHEAD0_EX_END),
      .iHEAD0_WRITEBACK(iHEAD0_WRITEBACK), .iHEAD0_MAKE_FLAGS(iHEAD0_MAKE_FLAGS),
      .iHEAD0_FLAGS_PREG(iHEAD0_FLAGS_PREG), .iHEAD0_DEST_PREG(iHEAD0_DEST_PREG),
      .iHEAD0_DEST_LREG(iHEAD0_DEST_LREG), .iHEAD0_DEST_SYSREG(iHEAD0_DEST_SYSREG),
      .iHEAD0_EX_BRANCH(iHEAD0_EX_BRANCH), .iHEAD0_PC(iHEAD0_PC),
      .iHEAD1_VALID(iHEAD1_VALID), .iHEAD1_EX_END(iHEAD1_EX_END),
      .iHEAD1_WRITEBACK(iHEAD1_WRITEBACK), .iHEAD1_MAKE_FLAGS(iHEAD1_MAKE_FLAGS),
      .iHEAD1_FLAGS_PREG(iHEAD1_FLAGS_PREG), .iHEAD1_DEST_PREG(iHEAD1_DEST_PREG),
      .iHEAD1_DEST_LREG(iHEAD1_DEST_LREG), .iHEAD1_DEST_SYSREG(iHEAD1_DEST_SYSREG),
      .iHEAD1_EX_BRANCH(iHEAD1_EX_BRANCH), .iHEAD1_PC(iHEAD1_PC),
      .oCOMMIT0_VALID(oCOMMIT0_VALID), .oCOMMIT0_POINTER(oCOMMIT0_POINTER),
      .oCOMMIT1_VALID(oCOMMIT1_VALID), .oCOMMIT1_POINTER(oCOMMIT1_POINTER),
      .oRETIRE0_VALID(oRETIRE0_VALID), .oRETIRE0_WRITEBACK(oRETIRE0_WRITEBACK),
      .oRETIRE0_MAKE_FLAGS(oRETIRE0_MAKE_FLAGS), .oRETIRE0_FLAGS_PREG(oRETIRE0_FLAGS_PREG),
      .oRETIRE0_DEST_PREG(oRETIRE0_DEST_PREG), .oRETIRE0_DEST_LREG(oRETIRE0_DEST_LREG),
      .oRETIRE0_DEST_SYSREG(oRETIRE0_DEST_SYSREG), .oRETIRE0_EX_BRANCH(oRETIRE0_EX_BRANCH),
      .oRETIRE0_PC(oRETIRE0_PC),
      .oRETIRE1_VALID(oRETIRE1_VALID), .oRETIRE1_WRITEBACK(oRETIRE1_WRITEBACK),
      .oRETIRE1_MAKE_FLAGS(oRETIRE1_MAKE_FLAGS), .oRETIRE1_FLAGS_PREG(oRETIRE1_FLAGS_PREG),
      .oRETIRE1_DEST_PREG(oRETIRE1_DEST_PREG), .oRETIRE1_DEST_LREG(oRETIRE1_DEST_LREG),
      .oRETIRE1_DEST_SYSREG(oRETIRE1_DEST_SYSREG), .oRETIRE1_EX_BRANCH(oRETIRE1_EX_BRANCH),
      .oRETIRE1_PC(oRETIRE1_PC),
      .oRETIRE_COUNT(oRETIRE_COUNT)
   );

   always #5 iCLOCK = ~iCLOCK;

   int checks = 0;
   int errors = 0;
   logic [50:0] q0[$];
   logic [50:0] q1[$];

   // Payload fields are derived from the PC so each retire record is distinct.
   function automatic logic [50:0] rec(input logic br, input logic [31:0] pc);
      return {pc[0], pc[1], pc[5:2], pc[11:6], pc[16:12], pc[17], br, pc};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drv0(input logic ex, input logic br, input logic [31:0] pc);
      iHEAD0_EX_END = ex; iHEAD0_EX_BRANCH = br; iHEAD0_PC = pc;
      iHEAD0_WRITEBACK = pc[0]; iHEAD0_MAKE_FLAGS = pc[1]; iHEAD0_FLAGS_PREG = pc[5:2];
      iHEAD0_DEST_PREG = pc[11:6]; iHEAD0_DEST_LREG = pc[16:12]; iHEAD0_DEST_SYSREG = pc[17];
   endtask

   task automatic drv1(input logic ex, input logic br, input logic [31:0] pc);
      iHEAD1_EX_END = ex; iHEAD1_EX_BRANCH = br; iHEAD1_PC = pc;
      iHEAD1_WRITEBACK = pc[0]; iHEAD1_MAKE_FLAGS = pc[1]; iHEAD1_FLAGS_PREG = pc[5:2];
      iHEAD1_DEST_PREG = pc[11:6]; iHEAD1_DEST_LREG = pc[16:12]; iHEAD1_DEST_SYSREG = pc[17];
   endtask

   task automatic tick();
      @(posedge iCLOCK); #1;
   endtask

   task automatic alloc(input logic r0, input logic r1);
      iREGIST_0_VALID = r0; iREGIST_1_VALID = r1;
      tick();
      iREGIST_0_VALID = 1'b0; iREGIST_1_VALID = 1'b0;
   endtask

   // Retire monitor: every retire the DUT presents must match the next expected record.
   always @(negedge iCLOCK) begin
      if (!iRESET) begin
         if (oRETIRE0_VALID) begin
            if (q0.size() == 0) chk("ret0_unexpected", 64'(oRETIRE0_PC), 64'h0 - 1);
            else chk("ret0_payload", 64'({oRETIRE0_WRITEBACK, oRETIRE0_MAKE_FLAGS, oRETIRE0_FLAGS_PREG,
                     oRETIRE0_DEST_PREG, oRETIRE0_DEST_LREG, oRETIRE0_DEST_SYSREG,
                     oRETIRE0_EX_BRANCH, oRETIRE0_PC}), 64'(q0.pop_front()));
         end else begin
            chk("ret0_idle_zero", 64'({oRETIRE0_WRITEBACK, oRETIRE0_MAKE_FLAGS, oRETIRE0_FLAGS_PREG,
                oRETIRE0_DEST_PREG, oRETIRE0_DEST_LREG, oRETIRE0_DEST_SYSREG,
                oRETIRE0_EX_BRANCH, oRETIRE0_PC}), 64'h0);
         end
         if (oRETIRE1_VALID) begin
            if (q1.size() == 0) chk("ret1_unexpected", 64'(oRETIRE1_PC), 64'h0 - 1);
            else chk("ret1_payload", 64'({oRETIRE1_WRITEBACK, oRETIRE1_MAKE_FLAGS, oRETIRE1_FLAGS_PREG,
                     oRETIRE1_DEST_PREG, oRETIRE1_DEST_LREG, oRETIRE1_DEST_SYSREG,
                     oRETIRE1_EX_BRANCH, oRETIRE1_PC}), 64'(q1.pop_front()));
         end else begin
            chk("ret1_idle_zero", 64'({oRETIRE1_WRITEBACK, oRETIRE1_MAKE_FLAGS, oRETIRE1_FLAGS_PREG,
                oRETIRE1_DEST_PREG, oRETIRE1_DEST_LREG, oRETIRE1_DEST_SYSREG,
                oRETIRE1_EX_BRANCH, oRETIRE1_PC}), 64'h0);
         end
      end
   end

   initial begin
      logic [31:0] pa, pb;
      iRESET = 1'b1; iLOCK = 1'b0; iRESTART_VALID = 1'b0;
      iREGIST_0_VALID = 1'b0; iREGIST_1_VALID = 1'b0;
      iHEAD0_VALID = 1'b1; iHEAD1_VALID = 1'b1;
      drv0(1'b0, 1'b0, 32'h0); drv1(1'b0, 1'b0, 32'h0);
      repeat (2) tick();
      chk("rst_head", 64'(oHEAD_POINTER), 64'd0);
      chk("rst_tail", 64'(oREGIST_POINTER), 64'd0);
      chk("rst_empty", 64'(oEMPTY), 64'd1);
      chk("rst_full", 64'(oFULL), 64'd0);
      chk("rst_count", 64'(oRETIRE_COUNT), 64'd0);
      chk("rst_ret_valid", 64'({oRETIRE0_VALID, oRETIRE1_VALID}), 64'd0);
      iRESET = 1'b0;
      tick();

      // Single allocate then single commit; a done head on an empty ring must not commit.
      drv0(1'b1, 1'b0, 32'h0003_F0C5);
      iREGIST_0_VALID = 1'b1; #1;
      chk("t1_empty_nocommit", 64'(oCOMMIT0_VALID), 64'd0);
      tick(); iREGIST_0_VALID = 1'b0;
      chk("t1_tail", 64'(oREGIST_POINTER), 64'd1);
      chk("t1_not_empty", 64'(oEMPTY), 64'd0);
      #1;
      chk("t1_c0", 64'(oCOMMIT0_VALID), 64'd1);
      chk("t1_p0", 64'(oCOMMIT0_POINTER), 64'd0);
      chk("t1_c1_count1", 64'(oCOMMIT1_VALID), 64'd0);
      q0.push_back(rec(1'b0, 32'h0003_F0C5));
      tick(); drv0(1'b0, 1'b0, 32'h0);
      chk("t1_head", 64'(oHEAD_POINTER), 64'd1);
      chk("t1_empty", 64'(oEMPTY), 64'd1);
      chk("t1_rcount", 64'(oRETIRE_COUNT), 64'd1);

      // Dual commit.
      alloc(1'b1, 1'b1);
      chk("t2_tail", 64'(oREGIST_POINTER), 64'd3);
      drv0(1'b1, 1'b0, 32'h1234_5678); drv1(1'b1, 1'b0, 32'h8765_4321); #1;
      chk("t2_c0", 64'(oCOMMIT0_VALID), 64'd1);
      chk("t2_c1", 64'(oCOMMIT1_VALID), 64'd1);
      chk("t2_p0", 64'(oCOMMIT0_POINTER), 64'd1);
      chk("t2_p1", 64'(oCOMMIT1_POINTER), 64'd2);
      q0.push_back(rec(1'b0, 32'h1234_5678)); q1.push_back(rec(1'b0, 32'h8765_4321));
      tick(); drv0(1'b0, 1'b0, 32'h0); drv1(1'b0, 1'b0, 32'h0);
      chk("t2_head", 64'(oHEAD_POINTER), 64'd3);
      chk("t2_rcount", 64'(oRETIRE_COUNT), 64'd3);

      // Branch at head retires alone.
      alloc(1'b1, 1'b1);
      drv0(1'b1, 1'b1, 32'hDEAD_BEEF); drv1(1'b1, 1'b0, 32'h0BAD_F00D); #1;
      chk("t3_c0", 64'(oCOMMIT0_VALID), 64'd1);
      chk("t3_c1_branch", 64'(oCOMMIT1_VALID), 64'd0);
      q0.push_back(rec(1'b1, 32'hDEAD_BEEF));
      tick();
      chk("t3_head_a", 64'(oHEAD_POINTER), 64'd4);
      drv0(1'b1, 1'b0, 32'h0BAD_F00D); drv1(1'b1, 1'b0, 32'h0); #1;
      chk("t3_c0_next", 64'(oCOMMIT0_VALID), 64'd1);
      chk("t3_p0_next", 64'(oCOMMIT0_POINTER), 64'd4);
      q0.push_back(rec(1'b0, 32'h0BAD_F00D));
      tick(); drv0(1'b0, 1'b0, 32'h0); drv1(1'b0, 1'b0, 32'h0);
      chk("t3_head_b", 64'(oHEAD_POINTER), 64'd5);
      chk("t3_rcount", 64'(oRETIRE_COUNT), 64'd5);

      // Count 5: allocate 2 while retiring 2, then drain to prove count held at 5.
      alloc(1'b1, 1'b1); alloc(1'b1, 1'b1); alloc(1'b1, 1'b0);
      iREGIST_0_VALID = 1'b1; iREGIST_1_VALID = 1'b1;
      drv0(1'b1, 1'b0, 32'h0001_1111); drv1(1'b1, 1'b0, 32'h0002_2222); #1;
      chk("t6_c0", 64'(oCOMMIT0_VALID), 64'd1);
      chk("t6_c1", 64'(oCOMMIT1_VALID), 64'd1);
      chk("t6_p0", 64'(oCOMMIT0_POINTER), 64'd5);
      q0.push_back(rec(1'b0, 32'h0001_1111)); q1.push_back(rec(1'b0, 32'h0002_2222));
      tick(); iREGIST_0_VALID = 1'b0; iREGIST_1_VALID = 1'b0;
      chk("t6_head", 64'(oHEAD_POINTER), 64'd7);
      chk("t6_tail", 64'(oREGIST_POINTER), 64'd12);
      for (int i = 0; i < 2; i++) begin
         pa = 32'h0040_0000 + 32'(i); pb = 32'h0050_0003 + 32'(i);
         drv0(1'b1, 1'b0, pa); drv1(1'b1, 1'b0, pb); #1;
         chk("t6_drain_c1", 64'(oCOMMIT1_VALID), 64'd1);
         q0.push_back(rec(1'b0, pa)); q1.push_back(rec(1'b0, pb));
         tick();
      end
      chk("t6_one_left", 64'(oEMPTY), 64'd0);
      drv0(1'b1, 1'b0, 32'h7777_0001); drv1(1'b1, 1'b0, 32'h7777_0002); #1;
      chk("t6_last_c0", 64'(oCOMMIT0_VALID), 64'd1);
      chk("t6_last_c1_count1", 64'(oCOMMIT1_VALID), 64'd0);
      q0.push_back(rec(1'b0, 32'h7777_0001));
      tick(); drv0(1'b0, 1'b0, 32'h0); drv1(1'b0, 1'b0, 32'h0);
      chk("t6_empty", 64'(oEMPTY), 64'd1);
      chk("t6_head_end", 64'(oHEAD_POINTER), 64'd12);
      chk("t6_rcount", 64'(oRETIRE_COUNT), 64'd12);

      // Restart at count 10 with a simultaneous allocation and done entries.
      for (int i = 0; i < 5; i++) alloc(1'b1, 1'b1);
      chk("t5_tail_pre", 64'(oREGIST_POINTER), 64'd22);
      iRESTART_VALID = 1'b1; iREGIST_0_VALID = 1'b1; iREGIST_1_VALID = 1'b1;
      drv0(1'b1, 1'b0, 32'h5555_AAAA); drv1(1'b1, 1'b0, 32'hAAAA_5555); #1;
      chk("t5_c0_blocked", 64'(oCOMMIT0_VALID), 64'd0);
      chk("t5_c1_blocked", 64'(oCOMMIT1_VALID), 64'd0);
      tick();
      iRESTART_VALID = 1'b0; iREGIST_0_VALID = 1'b0; iREGIST_1_VALID = 1'b0;
      drv0(1'b0, 1'b0, 32'h0); drv1(1'b0, 1'b0, 32'h0);
      chk("t5_head", 64'(oHEAD_POINTER), 64'd0);
      chk("t5_tail", 64'(oREGIST_POINTER), 64'd0);
      chk("t5_empty", 64'(oEMPTY), 64'd1);
      chk("t5_rcount_kept", 64'(oRETIRE_COUNT), 64'd12);

      // Walk head to 62 with steady dual alloc/retire.
      alloc(1'b1, 1'b1);
      for (int i = 0; i < 30; i++) begin
         pa = 32'h4000_0000 + 32'(i) * 32'h0001_0203; pb = ~pa;
         iREGIST_0_VALID = 1'b1; iREGIST_1_VALID = 1'b1;
         drv0(1'b1, 1'b0, pa); drv1(1'b1, 1'b0, pb); #1;
         chk("t4_walk_p0", 64'(oCOMMIT0_POINTER), 64'((2 * i) % 64));
         chk("t4_walk_c1", 64'(oCOMMIT1_VALID), 64'd1);
         q0.push_back(rec(1'b0, pa)); q1.push_back(rec(1'b0, pb));
         tick();
      end
      iREGIST_0_VALID = 1'b0; iREGIST_1_VALID = 1'b0;
      drv0(1'b1, 1'b0, 32'h0C0C_0C0C); drv1(1'b1, 1'b0, 32'h0303_0303); #1;
      q0.push_back(rec(1'b0, 32'h0C0C_0C0C)); q1.push_back(rec(1'b0, 32'h0303_0303));
      tick(); drv0(1'b0, 1'b0, 32'h0); drv1(1'b0, 1'b0, 32'h0);
      chk("t4_head62", 64'(oHEAD_POINTER), 64'd62);
      chk("t4_empty", 64'(oEMPTY), 64'd1);
      chk("t4_rcount", 64'(oRETIRE_COUNT), 64'd74);

      // Fill: 62 entries is not yet full, 63 is.
      for (int i = 0; i < 31; i++) alloc(1'b1, 1'b1);
      chk("t4_full_at62", 64'(oFULL), 64'd0);
      chk("t4_tail60", 64'(oREGIST_POINTER), 64'd60);
      alloc(1'b1, 1'b0);
      chk("t4_full_at63", 64'(oFULL), 64'd1);
      chk("t4_tail61", 64'(oREGIST_POINTER), 64'd61);
      alloc(1'b1, 1'b0);
      chk("t4_drop1_tail", 64'(oREGIST_POINTER), 64'd61);
      alloc(1'b1, 1'b1);
      chk("t4_drop2_tail", 64'(oREGIST_POINTER), 64'd61);
      chk("t4_still_full", 64'(oFULL), 64'd1);
      drv0(1'b1, 1'b0, 32'h6262_6262); drv1(1'b1, 1'b0, 32'h6363_6363); #1;
      chk("t4_p0_62", 64'(oCOMMIT0_POINTER), 64'd62);
      chk("t4_p1_63", 64'(oCOMMIT1_POINTER), 64'd63);
      chk("t4_wrap_c1", 64'(oCOMMIT1_VALID), 64'd1);
      q0.push_back(rec(1'b0, 32'h6262_6262)); q1.push_back(rec(1'b0, 32'h6363_6363));
      tick(); drv1(1'b0, 1'b0, 32'h0);
      chk("t4_head_wrap", 64'(oHEAD_POINTER), 64'd0);
      chk("t4_not_full", 64'(oFULL), 64'd0);
      chk("t4_rcount2", 64'(oRETIRE_COUNT), 64'd76);

      // Lock blocks allocation but not retire.
      iLOCK = 1'b1; iREGIST_0_VALID = 1'b1;
      drv0(1'b1, 1'b0, 32'h1F1F_0A0A); #1;
      chk("lock_c0", 64'(oCOMMIT0_VALID), 64'd1);
      q0.push_back(rec(1'b0, 32'h1F1F_0A0A));
      tick(); iLOCK = 1'b0; iREGIST_0_VALID = 1'b0; drv0(1'b0, 1'b0, 32'h0);
      chk("lock_tail", 64'(oREGIST_POINTER), 64'd61);
      chk("lock_head", 64'(oHEAD_POINTER), 64'd1);

      // Asynchronous reset while a retire is being presented.
      chk("t7_ret0_pre", 64'(oRETIRE0_VALID), 64'd1);
      iRESET = 1'b1; #1;
      chk("t7_ret0v", 64'(oRETIRE0_VALID), 64'd0);
      chk("t7_ret0pc", 64'(oRETIRE0_PC), 64'd0);
      chk("t7_head", 64'(oHEAD_POINTER), 64'd0);
      chk("t7_tail", 64'(oREGIST_POINTER), 64'd0);
      chk("t7_empty", 64'(oEMPTY), 64'd1);
      chk("t7_rcount", 64'(oRETIRE_COUNT), 64'd0);
      q0.delete(); q1.delete();
      tick(); iRESET = 1'b0;
      repeat (2) tick();
      chk("sb_drained", 64'(q0.size() + q1.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
